// File: rtl/byte_loader_pkg.sv
// Shared types and default sizes for the byte loader and the downstream
// deserializer / XOR stages.
package byte_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KEY,
        ST_MSG,
        ST_FIN
    } state_t;

    localparam int DEF_KEY_SIZE = 32;
    localparam int DEF_MSG_SIZE = 512;

    function automatic int bytes_of(input int bits);
        return bits / 8;
    endfunction

endpackage

// File: rtl/byte_loader_piso.sv
// 8-bit parallel-in / serial-out shift buffer, MSB first, with empty and
// last-bit flags. Loading is only expected while the buffer is empty.
module piso_byte (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] din,
    output logic       dout,
    output logic       empty,
    output logic       last
);

    logic [7:0] sreg;
    logic [3:0] bit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (en) begin
            if (load) begin
                sreg    <= din;
                bit_cnt <= 4'd8;
            end else if (bit_cnt != 4'd0) begin
                sreg    <= {sreg[6:0], 1'b0};
                bit_cnt <= bit_cnt - 4'd1;
            end
        end
    end

    assign dout  = sreg[7];
    assign empty = (bit_cnt == 4'd0);
    assign last  = (bit_cnt == 4'd1);

endmodule

// File: rtl/byte_loader.sv
// Accepts host bytes and serializes KEY_SIZE key bits followed by MSG_SIZE
// message bits, MSB first, with per-phase load strobes.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for iStart, no bytes accepted
// ST_KEY  | accepting key bytes, strobing oLoad_key
// ST_MSG  | accepting message bytes, strobing oLoad_msg
// ST_FIN  | one-cycle oDone pulse, then back to idle
module byte_loader
    import byte_loader_pkg::*;
#(
    parameter int KEY_SIZE = DEF_KEY_SIZE,
    parameter int MSG_SIZE = DEF_MSG_SIZE
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEn,
    input  logic       iStart,
    input  logic [7:0] iByte,
    input  logic       iByte_valid,
    output logic       oByte_ready,
    output logic       oSerial_out,
    output logic       oLoad_key,
    output logic       oLoad_msg,
    output logic       oBusy,
    output logic       oDone
);

    localparam int CW = $clog2(MSG_SIZE / 8) + 1;
    localparam logic [CW-1:0] KEY_BYTES = CW'(bytes_of(KEY_SIZE));
    localparam logic [CW-1:0] MSG_BYTES = CW'(bytes_of(MSG_SIZE));

    state_t        state, state_nxt;
    logic [CW-1:0] byte_cnt;
    logic [CW-1:0] phase_bytes;
    logic          in_phase;
    logic          accept;
    logic          phase_end;
    logic          buf_dout, buf_empty, buf_last;
    logic          strobe;

    piso_byte u_piso (
        .clk   (iClk),
        .rst   (iRst),
        .en    (iEn),
        .load  (accept),
        .din   (iByte),
        .dout  (buf_dout),
        .empty (buf_empty),
        .last  (buf_last)
    );

    assign in_phase    = (state == ST_KEY) || (state == ST_MSG);
    assign phase_bytes = (state == ST_KEY) ? KEY_BYTES : MSG_BYTES;
    assign oByte_ready = in_phase && buf_empty && (byte_cnt < phase_bytes);
    assign accept      = iEn && iByte_valid && oByte_ready;
    // Phase closes on the edge that retires the final bit of the final byte.
    assign phase_end   = in_phase && buf_last && (byte_cnt == phase_bytes);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (iStart)    state_nxt = ST_KEY;
            ST_KEY:  if (phase_end) state_nxt = ST_MSG;
            ST_MSG:  if (phase_end) state_nxt = ST_FIN;
            ST_FIN:                 state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
        end else if (iEn) begin
            state <= state_nxt;
            if (state_nxt != state) begin
                byte_cnt <= '0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + CW'(1);
            end
        end
    end

    assign strobe      = iEn && in_phase && !buf_empty;
    assign oLoad_key   = strobe && (state == ST_KEY);
    assign oLoad_msg   = strobe && (state == ST_MSG);
    assign oSerial_out = strobe && buf_dout;
    assign oBusy       = (state != ST_IDLE);
    assign oDone       = (state == ST_FIN);

endmodule

// File: tb/tb_byte_loader.sv
// Directed self-checking bench for byte_loader: back-to-back load, gapped
// load with enable stalls, mid-sequence reset, and ignored start/bytes.
module tb_byte_loader;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iEn = 1'b1;
    logic       iStart = 1'b0;
    logic [7:0] iByte = 8'h00;
    logic       iByte_valid = 1'b0;
    logic       oByte_ready, oSerial_out, oLoad_key, oLoad_msg, oBusy, oDone;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int both_err = 0;
    int ser_err = 0;
    int done_cnt = 0;
    bit kq[$];
    bit mq[$];
    int kc[$];
    logic [7:0] exp_msg [64];

    byte_loader dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iEn         (iEn),
        .iStart      (iStart),
        .iByte       (iByte),
        .iByte_valid (iByte_valid),
        .oByte_ready (oByte_ready),
        .oSerial_out (oSerial_out),
        .oLoad_key   (oLoad_key),
        .oLoad_msg   (oLoad_msg),
        .oBusy       (oBusy),
        .oDone       (oDone)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    // Records every presented bit; checks are made later from the initial block.
    always @(negedge iClk) begin
        if (oLoad_key) begin
            kq.push_back(oSerial_out);
            kc.push_back(cyc);
        end
        if (oLoad_msg) mq.push_back(oSerial_out);
        if (oLoad_key && oLoad_msg) both_err++;
        if (!oLoad_key && !oLoad_msg && oSerial_out) ser_err++;
        if (oDone) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic pulse_start();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        iByte = b;
        iByte_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge iClk);
            acc = oByte_ready && iEn;
            tick();
            n++;
        end
        iByte_valid = 1'b0;
        chk("accept", 32'(acc), 32'd1);
    endtask

    task automatic en_gap();
        int s;
        s = 0;
        repeat (3) tick();
        iEn = 1'b0;
        repeat (3) begin
            @(negedge iClk);
            if (oLoad_key || oLoad_msg) s++;
            tick();
        end
        iEn = 1'b1;
        chk("en_low_strobe", 32'(s), 32'd0);
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        do begin
            @(negedge iClk);
            n++;
        end while (!oDone && n < 100);
        chk(tag, 32'(oDone), 32'd1);
    endtask

    task automatic check_run(input string tag, input int kb, input int mb, input logic [31:0] key);
        logic [31:0] w;
        logic [7:0]  b;
        int bad;
        w   = '0;
        bad = 0;
        chk({tag, "_key_bits"}, 32'(kq.size() - kb), 32'd32);
        chk({tag, "_msg_bits"}, 32'(mq.size() - mb), 32'd512);
        for (int i = 0; i < 32; i++)
            if (kb + i < kq.size()) w = {w[30:0], kq[kb + i]};
        chk({tag, "_key_stream"}, w, key);
        for (int i = 0; i < 64; i++) begin
            b = '0;
            for (int j = 0; j < 8; j++)
                if (mb + 8 * i + j < mq.size()) b = {b[6:0], mq[mb + 8 * i + j]};
            if (b !== exp_msg[i]) bad++;
        end
        chk({tag, "_msg_stream_bad_bytes"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int kb, mb, kcb, dcb, n, rdy;
        logic [7:0] key_bytes [4];

        // Reset and idle behaviour
        repeat (3) tick();
        iRst = 1'b0;
        @(negedge iClk);
        chk("reset_outputs", 32'({oByte_ready, oSerial_out, oLoad_key, oLoad_msg, oBusy, oDone}), 32'd0);
        tick();

        iByte = 8'h55;
        iByte_valid = 1'b1;
        rdy = 0;
        repeat (5) begin
            @(negedge iClk);
            if (oByte_ready) rdy++;
            tick();
        end
        iByte_valid = 1'b0;
        chk("idle_ready", 32'(rdy), 32'd0);
        chk("idle_busy", 32'(oBusy), 32'd0);

        iRst = 1'b1;
        iStart = 1'b1;
        tick();
        iRst = 1'b0;
        iStart = 1'b0;
        @(negedge iClk);
        chk("rst_start_busy", 32'(oBusy), 32'd0);
        chk("rst_start_ready", 32'(oByte_ready), 32'd0);
        tick();

        // Run 1: back-to-back key DEADBEEF, message 0x00..0x3F
        for (int i = 0; i < 64; i++) exp_msg[i] = 8'(i);
        pulse_start();
        @(negedge iClk);
        chk("start_busy", 32'(oBusy), 32'd1);
        chk("start_ready", 32'(oByte_ready), 32'd1);
        tick();
        kb = kq.size(); mb = mq.size(); kcb = kc.size(); dcb = done_cnt;
        key_bytes[0] = 8'hDE; key_bytes[1] = 8'hAD; key_bytes[2] = 8'hBE; key_bytes[3] = 8'hEF;
        for (int i = 0; i < 4; i++) send_byte(key_bytes[i]);
        repeat (8) @(negedge iClk);
        @(negedge iClk);
        chk("key_to_msg_ready", 32'(oByte_ready), 32'd1);
        chk("key_to_msg_no_strobe", 32'({oLoad_key, oLoad_msg}), 32'd0);
        tick();
        chk("key_count", 32'(kq.size() - kb), 32'd32);
        if (kc.size() >= kcb + 32) chk("key_span_bubbles", 32'(kc[kcb + 31] - kc[kcb]), 32'd34);
        else chk("key_span_bubbles", 32'(kc.size() - kcb), 32'd32);
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(i));
            if (i == 10) begin
                pulse_start();
                chk("msg_start_ignored_busy", 32'(oBusy), 32'd1);
            end
        end
        wait_done("run1_done", n);
        chk("run1_done_latency", 32'(n), 32'd9);
        chk("fin_busy", 32'(oBusy), 32'd1);
        chk("fin_ready", 32'(oByte_ready), 32'd0);
        tick();
        @(negedge iClk);
        chk("post_fin_done", 32'(oDone), 32'd0);
        chk("post_fin_busy", 32'(oBusy), 32'd0);
        tick();
        chk("run1_done_once", 32'(done_cnt - dcb), 32'd1);
        check_run("run1", kb, mb, 32'hDEADBEEF);

        // Run 2: valid gaps and enable stalls mid-byte
        for (int i = 0; i < 64; i++) exp_msg[i] = 8'(i * 37 + 5);
        pulse_start();
        kb = kq.size(); mb = mq.size(); dcb = done_cnt;
        key_bytes[0] = 8'h12; key_bytes[1] = 8'h34; key_bytes[2] = 8'h56; key_bytes[3] = 8'h78;
        for (int i = 0; i < 4; i++) begin
            send_byte(key_bytes[i]);
            if (i == 1) en_gap();
            if (i == 2) repeat (5) tick();
        end
        for (int i = 0; i < 64; i++) begin
            send_byte(exp_msg[i]);
            if (i % 8 == 3) en_gap();
            if (i % 8 == 5) repeat (5) tick();
        end
        en_gap();
        wait_done("run2_done", n);
        tick();
        tick();
        chk("run2_done_once", 32'(done_cnt - dcb), 32'd1);
        check_run("run2", kb, mb, 32'h12345678);

        // Run 3: reset after 20 message bytes, with enable low during reset
        pulse_start();
        key_bytes[0] = 8'hA5; key_bytes[1] = 8'h5A; key_bytes[2] = 8'hC3; key_bytes[3] = 8'h3C;
        for (int i = 0; i < 4; i++) send_byte(key_bytes[i]);
        for (int i = 0; i < 20; i++) send_byte(8'(i + 100));
        iRst = 1'b1;
        iEn = 1'b0;
        tick();
        @(negedge iClk);
        chk("mid_reset_outputs", 32'({oByte_ready, oSerial_out, oLoad_key, oLoad_msg, oBusy, oDone}), 32'd0);
        tick();
        iRst = 1'b0;
        iEn = 1'b1;
        kb = kq.size(); mb = mq.size();
        iByte = 8'hFF;
        iByte_valid = 1'b1;
        rdy = 0;
        repeat (10) begin
            @(negedge iClk);
            if (oByte_ready) rdy++;
            tick();
        end
        iByte_valid = 1'b0;
        chk("post_reset_ready", 32'(rdy), 32'd0);
        chk("post_reset_busy", 32'(oBusy), 32'd0);
        chk("post_reset_strobes", 32'((kq.size() - kb) + (mq.size() - mb)), 32'd0);

        chk("no_dual_strobe", 32'(both_err), 32'd0);
        chk("serial_quiet", 32'(ser_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
